// File: rtl/conv_addr_seq.sv
// conv_addr_seq: runtime-configurable address sequencer for one conv tile.
// Walks K x K taps over every output window, input slice and output block,
// issues in_fm/weight read addresses, and emits delayed out_fm read/write
// strobes with their accumulation addresses.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// CHECK  | latch configuration, reject illegal shapes
// RUN    | one tap per non-stalled cycle
// DRAIN  | all taps issued, waiting for the last out_fm write strobe
// DONE   | one-cycle completion pulse
module conv_addr_seq #(
    parameter int AW         = 16,
    parameter int CW         = 16,
    parameter int PIPE_DELAY = 40,
    parameter int WR_DELAY   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          stall,
    input  logic [3:0]    cfg_k,
    input  logic [3:0]    cfg_s,
    input  logic [CW-1:0] cfg_tr,
    input  logic [CW-1:0] cfg_tc,
    input  logic [7:0]    cfg_slices,
    input  logic [7:0]    cfg_blocks,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic          kernel_start,
    output logic          rd_vld,
    output logic [AW-1:0] in_fm_rd_addr,
    output logic [AW-1:0] weight_rd_addr,
    output logic          out_fm_rd_ena,
    output logic [AW-1:0] out_fm_rd_addr,
    output logic          out_fm_wr_ena,
    output logic [AW-1:0] out_fm_wr_addr
);

    localparam int MW = 2 * CW + 8;
    localparam int DW = $clog2(PIPE_DELAY + WR_DELAY + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state;
    logic [3:0]    sh_k, sh_s;
    logic [CW-1:0] sh_tr, sh_tc;
    logic [7:0]    sh_slices, sh_blocks, sh_kk;
    logic [3:0]    cnt_j, cnt_i;
    logic [CW-1:0] cnt_col, cnt_row;
    logic [7:0]    cnt_slice, cnt_block;
    logic [AW-1:0] out_idx, blk_base;
    logic          kl_q;
    logic [AW-1:0] oidx_q;
    logic [DW-1:0] drain_cnt;

    logic          rp_ena  [PIPE_DELAY];
    logic [AW-1:0] rp_addr [PIPE_DELAY];
    logic          wp_ena  [WR_DELAY];
    logic [AW-1:0] wp_addr [WR_DELAY];

    logic          tap, j_last, i_last, col_last, row_last, slice_last, block_last;
    logic          win_last, final_tap, cfg_bad;
    logic [CW:0]   col_end, row_end;
    logic [AW-1:0] in_lin, wt_lin;

    assign tap        = (state == S_RUN) && !stall;
    assign j_last     = (cnt_j == sh_k - 4'd1);
    assign i_last     = (cnt_i == sh_k - 4'd1);
    // Window after this one would end at origin + S + K; past the edge means last.
    assign col_end    = {1'b0, cnt_col} + (CW+1)'(sh_s) + (CW+1)'(sh_k);
    assign row_end    = {1'b0, cnt_row} + (CW+1)'(sh_s) + (CW+1)'(sh_k);
    assign col_last   = (col_end > {1'b0, sh_tc});
    assign row_last   = (row_end > {1'b0, sh_tr});
    assign slice_last = (cnt_slice == sh_slices - 8'd1);
    assign block_last = (cnt_block == sh_blocks - 8'd1);
    assign win_last   = j_last && i_last;
    assign final_tap  = tap && win_last && col_last && row_last && slice_last && block_last;

    assign cfg_bad = (cfg_k == 4'd0) || (cfg_s == 4'd0) ||
                     (CW'(cfg_k) > cfg_tr) || (CW'(cfg_k) > cfg_tc) ||
                     (cfg_slices == 8'd0) || (cfg_blocks == 8'd0);

    assign in_lin = AW'(MW'(cnt_row + CW'(cnt_i)) * MW'(sh_tc) + MW'(cnt_col) + MW'(cnt_j));
    assign wt_lin = AW'((MW'(cnt_block) * MW'(sh_slices) + MW'(cnt_slice)) * MW'(sh_kk)
                        + MW'(cnt_i) * MW'(sh_k) + MW'(cnt_j));

    // Control FSM: state, loop counters, output indexing and registered tap outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || abort) begin
            state          <= S_IDLE;
            sh_k           <= '0;
            sh_s           <= '0;
            sh_tr          <= '0;
            sh_tc          <= '0;
            sh_slices      <= '0;
            sh_blocks      <= '0;
            sh_kk          <= '0;
            cnt_j          <= '0;
            cnt_i          <= '0;
            cnt_col        <= '0;
            cnt_row        <= '0;
            cnt_slice      <= '0;
            cnt_block      <= '0;
            out_idx        <= '0;
            blk_base       <= '0;
            kl_q           <= 1'b0;
            oidx_q         <= '0;
            drain_cnt      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
            kernel_start   <= 1'b0;
            rd_vld         <= 1'b0;
            in_fm_rd_addr  <= '0;
            weight_rd_addr <= '0;
        end else begin
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            rd_vld       <= tap;
            kernel_start <= tap && (cnt_i == 4'd0) && (cnt_j == 4'd0);
            kl_q         <= tap && win_last;
            if (tap) begin
                in_fm_rd_addr  <= in_lin;
                weight_rd_addr <= wt_lin;
                oidx_q         <= out_idx;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CHECK;
                        busy  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    sh_k      <= cfg_k;
                    sh_s      <= cfg_s;
                    sh_tr     <= cfg_tr;
                    sh_tc     <= cfg_tc;
                    sh_slices <= cfg_slices;
                    sh_blocks <= cfg_blocks;
                    sh_kk     <= 8'(cfg_k) * 8'(cfg_k);
                    cnt_j     <= '0;
                    cnt_i     <= '0;
                    cnt_col   <= '0;
                    cnt_row   <= '0;
                    cnt_slice <= '0;
                    cnt_block <= '0;
                    out_idx   <= '0;
                    blk_base  <= '0;
                    if (cfg_bad) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        cfg_err <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (tap) begin
                        if (!j_last) cnt_j <= cnt_j + 4'd1;
                        else begin
                            cnt_j <= '0;
                            if (!i_last) cnt_i <= cnt_i + 4'd1;
                            else begin
                                cnt_i <= '0;
                                if (!col_last) cnt_col <= cnt_col + CW'(sh_s);
                                else begin
                                    cnt_col <= '0;
                                    if (!row_last) cnt_row <= cnt_row + CW'(sh_s);
                                    else begin
                                        cnt_row <= '0;
                                        if (!slice_last) cnt_slice <= cnt_slice + 8'd1;
                                        else begin
                                            cnt_slice <= '0;
                                            if (!block_last) cnt_block <= cnt_block + 8'd1;
                                            else cnt_block <= '0;
                                        end
                                    end
                                end
                            end
                        end
                        // Every slice of a block accumulates into the same output range.
                        if (win_last) begin
                            if (col_last && row_last) begin
                                if (slice_last) begin
                                    out_idx  <= out_idx + AW'(1);
                                    blk_base <= out_idx + AW'(1);
                                end else begin
                                    out_idx <= blk_base;
                                end
                            end else begin
                                out_idx <= out_idx + AW'(1);
                            end
                        end
                        if (final_tap) begin
                            state     <= S_DRAIN;
                            drain_cnt <= DW'(PIPE_DELAY + WR_DELAY);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobe delay lines; each address stage only loads with a valid strobe so
    // the outputs hold the last strobed address between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || abort) begin
            for (int k = 0; k < PIPE_DELAY; k++) begin
                rp_ena[k]  <= 1'b0;
                rp_addr[k] <= '0;
            end
            for (int k = 0; k < WR_DELAY; k++) begin
                wp_ena[k]  <= 1'b0;
                wp_addr[k] <= '0;
            end
        end else begin
            rp_ena[0] <= kl_q;
            if (kl_q) rp_addr[0] <= oidx_q;
            for (int k = 1; k < PIPE_DELAY; k++) begin
                rp_ena[k] <= rp_ena[k-1];
                if (rp_ena[k-1]) rp_addr[k] <= rp_addr[k-1];
            end
            wp_ena[0] <= rp_ena[PIPE_DELAY-1];
            if (rp_ena[PIPE_DELAY-1]) wp_addr[0] <= rp_addr[PIPE_DELAY-1];
            for (int k = 1; k < WR_DELAY; k++) begin
                wp_ena[k] <= wp_ena[k-1];
                if (wp_ena[k-1]) wp_addr[k] <= wp_addr[k-1];
            end
        end
    end

    assign out_fm_rd_ena  = rp_ena[PIPE_DELAY-1];
    assign out_fm_rd_addr = rp_addr[PIPE_DELAY-1];
    assign out_fm_wr_ena  = wp_ena[WR_DELAY-1];
    assign out_fm_wr_addr = wp_addr[WR_DELAY-1];

endmodule

// File: tb/tb_conv_addr_seq.sv
// Bench for conv_addr_seq: a loop-nest model fills a tap scoreboard; a
// monitor pops it on rd_vld and schedules expected out_fm strobes.
module tb_conv_addr_seq;

    localparam int AW = 16;
    localparam int CW = 16;
    localparam int PD = 40;
    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, stall = 1'b0;
    logic [3:0]    cfg_k = '0, cfg_s = '0;
    logic [CW-1:0] cfg_tr = '0, cfg_tc = '0;
    logic [7:0]    cfg_slices = '0, cfg_blocks = '0;
    logic          busy, done, cfg_err, kernel_start, rd_vld;
    logic [AW-1:0] in_fm_rd_addr, weight_rd_addr, out_fm_rd_addr, out_fm_wr_addr;
    logic          out_fm_rd_ena, out_fm_wr_ena;

    conv_addr_seq #(.AW(AW), .CW(CW), .PIPE_DELAY(PD), .WR_DELAY(WD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
        .cfg_k(cfg_k), .cfg_s(cfg_s), .cfg_tr(cfg_tr), .cfg_tc(cfg_tc),
        .cfg_slices(cfg_slices), .cfg_blocks(cfg_blocks),
        .busy(busy), .done(done), .cfg_err(cfg_err), .kernel_start(kernel_start),
        .rd_vld(rd_vld), .in_fm_rd_addr(in_fm_rd_addr), .weight_rd_addr(weight_rd_addr),
        .out_fm_rd_ena(out_fm_rd_ena), .out_fm_rd_addr(out_fm_rd_addr),
        .out_fm_wr_ena(out_fm_wr_ena), .out_fm_wr_addr(out_fm_wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in_a;
        logic [31:0] w_a;
        logic [31:0] oa;
        logic        ks;
        logic        kl;
    } tap_t;

    typedef struct {
        int          t;
        logic [31:0] a;
    } str_t;

    tap_t q_tap[$];
    str_t q_rd[$];
    str_t q_wr[$];

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int vld_count = 0, gaps = 0, stray = 0, last_vld = 0;
    bit first_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference loop nest written over output positions (oy, ox) rather than origins.
    task automatic build_exp(input int k, input int s, input int tr, input int tc,
                             input int nsl, input int nbl, output int n);
        tap_t e;
        int oh, ow;
        oh = (tr - k) / s + 1;
        ow = (tc - k) / s + 1;
        n = 0;
        q_tap.delete();
        q_rd.delete();
        q_wr.delete();
        for (int b = 0; b < nbl; b++)
            for (int sl = 0; sl < nsl; sl++)
                for (int oy = 0; oy < oh; oy++)
                    for (int ox = 0; ox < ow; ox++)
                        for (int i = 0; i < k; i++)
                            for (int j = 0; j < k; j++) begin
                                e.in_a = 32'((oy * s + i) * tc + ox * s + j);
                                e.w_a  = 32'((b * nsl + sl) * k * k + i * k + j);
                                e.oa   = 32'(b * oh * ow + oy * ow + ox);
                                e.ks   = (i == 0) && (j == 0);
                                e.kl   = (i == k - 1) && (j == k - 1);
                                q_tap.push_back(e);
                                n++;
                            end
    endtask

    // Monitor: compares taps and strobes against the scoreboard queues.
    always @(negedge clk) begin : mon
        tap_t e;
        str_t r, w;
        if (!rst) begin
            if (rd_vld) begin
                vld_count++;
                last_vld   = cyc;
                first_seen = 1;
                check("tap_expected", 32'(q_tap.size() != 0), 32'd1);
                if (q_tap.size() != 0) begin
                    e = q_tap.pop_front();
                    check("in_fm_rd_addr", 32'(in_fm_rd_addr), e.in_a);
                    check("weight_rd_addr", 32'(weight_rd_addr), e.w_a);
                    check("kernel_start", 32'(kernel_start), 32'(e.ks));
                    if (e.kl) begin
                        r.t = cyc + PD;
                        r.a = e.oa;
                        q_rd.push_back(r);
                    end
                end
            end else begin
                if (kernel_start) stray++;
                if (first_seen && q_tap.size() != 0) gaps++;
            end
            if (out_fm_rd_ena) begin
                check("rd_strobe_expected", 32'(q_rd.size() != 0), 32'd1);
                if (q_rd.size() != 0) begin
                    r = q_rd.pop_front();
                    check("rd_strobe_cycle", 32'(cyc), 32'(r.t));
                    check("out_fm_rd_addr", 32'(out_fm_rd_addr), r.a);
                    w.t = r.t + WD;
                    w.a = r.a;
                    q_wr.push_back(w);
                end
            end
            if (out_fm_wr_ena) begin
                check("wr_strobe_expected", 32'(q_wr.size() != 0), 32'd1);
                if (q_wr.size() != 0) begin
                    w = q_wr.pop_front();
                    check("wr_strobe_cycle", 32'(cyc), 32'(w.t));
                    check("out_fm_wr_addr", 32'(out_fm_wr_addr), w.a);
                end
            end
        end
    end

    task automatic run_tile(input int k, input int s, input int tr, input int tc,
                            input int nsl, input int nbl, input int stall_at,
                            input int stall_len, input int abort_at, input bit chg_cfg);
        int n, c0, done_cyc, stall_cnt, quiet;
        bit done_seen, stalled;
        cfg_k = 4'(k); cfg_s = 4'(s); cfg_tr = CW'(tr); cfg_tc = CW'(tc);
        cfg_slices = 8'(nsl); cfg_blocks = 8'(nbl);
        build_exp(k, s, tr, tc, nsl, nbl, n);
        vld_count = 0; gaps = 0; stray = 0; first_seen = 0;
        done_seen = 0; stalled = 0; stall_cnt = 0; done_cyc = 0;
        @(negedge clk); #1;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < n + PD + WD + 40 && !done_seen; t++) begin
            @(negedge clk); #1;
            if (chg_cfg && vld_count == 2) begin
                cfg_k = 4'd1; cfg_s = 4'd3; cfg_tr = CW'(9); cfg_tc = CW'(2);
            end
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) stall = 1'b0;
            end else if (!stalled && stall_at >= 0 && vld_count == stall_at) begin
                stall     = 1'b1;
                stalled   = 1;
                stall_cnt = stall_len;
            end
            if (abort_at >= 0 && vld_count == abort_at) begin
                abort = 1'b1;
                @(negedge clk); #1;
                abort = 1'b0;
                q_tap.delete();
                q_rd.delete();
                q_wr.delete();
                check("abort_busy_low", 32'(busy), 32'd0);
                quiet = 0;
                repeat (PD + WD + 20) begin
                    @(negedge clk); #1;
                    quiet += int'(rd_vld | kernel_start | out_fm_rd_ena | out_fm_wr_ena | done | busy);
                end
                check("abort_quiet_cycles", 32'(quiet), 32'd0);
                return;
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                check("busy_low_with_done", 32'(busy), 32'd0);
            end
        end
        check("done_seen", 32'(done_seen), 32'd1);
        check("done_latency_from_start", 32'(done_cyc - c0), 32'(n + PD + WD + 3 + stall_len));
        check("done_after_last_tap", 32'(done_cyc - last_vld), 32'(PD + WD + 1));
        @(negedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("scoreboard_drained", 32'(q_tap.size() + q_rd.size() + q_wr.size()), 32'd0);
        check("tap_count", 32'(vld_count), 32'(n));
        check("rd_vld_gap_cycles", 32'(gaps), 32'(stall_len));
        check("kernel_start_without_vld", 32'(stray), 32'd0);
    endtask

    task automatic run_err(input int k, input int s, input int tr, input int tc,
                           input int nsl, input int nbl);
        int c0, errs, err_cyc, quiet;
        logic busy_at_err;
        cfg_k = 4'(k); cfg_s = 4'(s); cfg_tr = CW'(tr); cfg_tc = CW'(tc);
        cfg_slices = 8'(nsl); cfg_blocks = 8'(nbl);
        errs = 0; err_cyc = 0; quiet = 0; busy_at_err = 1'b1;
        @(negedge clk); #1;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        check("err_busy_in_check", 32'(busy), 32'd1);
        repeat (20) begin
            @(negedge clk); #1;
            if (cfg_err) begin
                errs++;
                err_cyc     = cyc;
                busy_at_err = busy;
            end
            quiet += int'(rd_vld | out_fm_rd_ena | out_fm_wr_ena | done);
        end
        check("cfg_err_pulses", 32'(errs), 32'd1);
        check("cfg_err_cycle", 32'(err_cyc - c0), 32'd2);
        check("err_busy_at_pulse", 32'(busy_at_err), 32'd0);
        check("err_busy_after", 32'(busy), 32'd0);
        check("err_no_activity", 32'(quiet), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ctrl_outputs",
              32'({busy, done, cfg_err, kernel_start, rd_vld, out_fm_rd_ena, out_fm_wr_ena}), 32'd0);
        check("rst_in_fm_rd_addr", 32'(in_fm_rd_addr), 32'd0);
        check("rst_weight_rd_addr", 32'(weight_rd_addr), 32'd0);
        check("rst_out_fm_addrs", 32'({out_fm_rd_addr, out_fm_wr_addr}), 32'd0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // K=3 S=1 5x5, one slice, one block
        run_tile(3, 1, 5, 5, 1, 1, -1, 0, -1, 0);
        // K=3 S=2 7x7
        run_tile(3, 2, 7, 7, 1, 1, -1, 0, -1, 0);
        // K=2 S=1 3x3, two slices, two blocks
        run_tile(2, 1, 3, 3, 2, 2, -1, 0, -1, 0);
        // stall 5 cycles at tap 20, config inputs changed mid-run
        run_tile(3, 1, 5, 5, 1, 1, 20, 5, -1, 1);
        // illegal configurations
        run_err(4, 1, 5, 3, 1, 1);
        run_err(3, 0, 5, 5, 1, 1);
        // abort at tap 40, then an immediate clean rerun
        run_tile(3, 1, 5, 5, 1, 1, -1, 0, 40, 0);
        run_tile(3, 1, 5, 5, 1, 1, -1, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
